systolic_operand_feeder: RTL and testbench

- Producer that drives the input side of the parameterized systolic array.
- Holds one N x N operand matrix A and one N x N operand matrix B, loaded element-serially.
- On start, streams N beats to the array: beat k carries column k of A and row k of B, with a valid strobe.
- Enforces a programmable idle gap so consecutive matrix products never overlap inside the array.

---
 rtl/systolic_operand_feeder.sv | 121 ++++++++++++
 tb/tb_systolic_operand_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: holds operand matrices A and B and streams them into a systolic array one beat per cycle
module systolic_operand_feeder #(
   parameter int DATAWIDTH  = 16,
   parameter int N_SIZE     = 5,
   parameter int GAP_CYCLES = 10
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              wr_en,
   input  logic                              wr_sel,
   input  logic [$clog2(N_SIZE*N_SIZE)-1:0]  wr_addr,
   input  logic [DATAWIDTH-1:0]              wr_data,
   output logic                              wr_err,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              valid_out,
   output logic [N_SIZE*DATAWIDTH-1:0]       matrix_a_out,
   output logic [N_SIZE*DATAWIDTH-1:0]       matrix_b_out
);
   localparam int NN = N_SIZE * N_SIZE;
   localparam int AW = $clog2(NN);
   localparam int KW = N_SIZE > 1 ? $clog2(N_SIZE) : 1;
   localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] GAP    = 2'd2;

   logic [1:0]                  state;
   logic [KW-1:0]               k;
   logic [KW-1:0]               nk;
   logic [GW-1:0]               gap_cnt;
   logic [DATAWIDTH-1:0]        bank_a [NN];
   logic [DATAWIDTH-1:0]        bank_b [NN];
   logic [N_SIZE*DATAWIDTH-1:0] beat_a;
   logic [N_SIZE*DATAWIDTH-1:0] beat_b;
   logic                        wr_ok;
   logic                        last_beat;
   logic                        gap_end;

   // next beat index: beat 0 on a start from IDLE, otherwise the one after the beat on the bus
   always_comb begin
      nk        = (state == IDLE) ? '0 : k + 1'b1;
      last_beat = (k == KW'(N_SIZE - 1));
      gap_end   = (gap_cnt == GW'(GAP_CYCLES - 1));
      wr_ok     = wr_en && (state == IDLE) && !start && (32'(wr_addr) < NN);
   end

   // beat nk: slice i of A is column element A[i][nk], slice j of B is row element B[nk][j]
   for (genvar i = 0; i < N_SIZE; i++) begin : g_slice
      assign beat_a[i*DATAWIDTH +: DATAWIDTH] = bank_a[AW'(i * N_SIZE) + AW'(nk)];
      assign beat_b[i*DATAWIDTH +: DATAWIDTH] = bank_b[AW'(nk) * AW'(N_SIZE) + AW'(i)];
   end

   // operand banks: writes commit only in IDLE without a competing start; anything else flags wr_err
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NN; n++) begin
            bank_a[n] <= '0;
            bank_b[n] <= '0;
         end
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && !wr_ok;
         if (wr_ok && !wr_sel) bank_a[wr_addr] <= wr_data;
         if (wr_ok && wr_sel) bank_b[wr_addr] <= wr_data;
      end
   end

   // run sequencer: IDLE -> STREAM for N_SIZE beats -> GAP for GAP_CYCLES cycles -> IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         k            <= '0;
         gap_cnt      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         valid_out    <= 1'b0;
         matrix_a_out <= '0;
         matrix_b_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= STREAM;
                  k            <= '0;
                  busy         <= 1'b1;
                  valid_out    <= 1'b1;
                  matrix_a_out <= beat_a;
                  matrix_b_out <= beat_b;
               end
            end
            STREAM: begin
               if (last_beat) begin
                  state        <= (GAP_CYCLES == 0) ? IDLE : GAP;
                  busy         <= (GAP_CYCLES != 0);
                  gap_cnt      <= '0;
                  done         <= 1'b1;
                  valid_out    <= 1'b0;
                  matrix_a_out <= '0;
                  matrix_b_out <= '0;
               end else begin
                  k            <= nk;
                  matrix_a_out <= beat_a;
                  matrix_b_out <= beat_b;
               end
            end
            GAP: begin
               if (gap_end) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// tb_systolic_operand_feeder: directed stimulus with a beat scoreboard checked by an independent monitor
module tb_systolic_operand_feeder;
   localparam int W = 16;
   localparam int N = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic          wr_sel = 1'b0;
   logic [4:0]    wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic          wr_err;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic          valid_out;
   logic [N*W-1:0] matrix_a_out;
   logic [N*W-1:0] matrix_b_out;

   int total = 0;
   int bad = 0;
   logic [2*N*W-1:0] q[$];
   logic [W-1:0] ma [N*N];
   logic [W-1:0] mb [N*N];

   systolic_operand_feeder #(.DATAWIDTH(W), .N_SIZE(N), .GAP_CYCLES(10)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_err(wr_err), .start(start), .busy(busy), .done(done),
      .valid_out(valid_out), .matrix_a_out(matrix_a_out), .matrix_b_out(matrix_b_out)
   );

   always #5 clk = ~clk;

   task automatic chkw(string nm, logic [N*W-1:0] act, logic [N*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic chkb(string nm, logic act, logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*W-1:0] mod_a(int k);
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = ma[i*N + k];
      return r;
   endfunction

   function automatic logic [N*W-1:0] mod_b(int k);
      logic [N*W-1:0] r;
      for (int j = 0; j < N; j++) r[j*W +: W] = mb[k*N + j];
      return r;
   endfunction

   task automatic push_model();
      for (int k = 0; k < N; k++) q.push_back({mod_a(k), mod_b(k)});
   endtask

   task automatic wr(logic sel, int addr, logic [W-1:0] data, logic exp_err);
      wr_en = 1'b1;
      wr_sel = sel;
      wr_addr = 5'(addr);
      wr_data = data;
      tick();
      wr_en = 1'b0;
      chkb("wr_err", wr_err, exp_err);
      if (!exp_err && sel) mb[addr] = data;
      if (!exp_err && !sel) ma[addr] = data;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chkb("first_valid", valid_out, 1'b1);
      chkb("busy_rise", busy, 1'b1);
   endtask

   task automatic finish_run(output int n);
      int m = 0;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chkb("done_seen", done, 1'b1);
      chkb("valid_at_done", valid_out, 1'b0);
      while (busy && m < 40) begin
         tick();
         m++;
      end
      chkb("busy_fall", busy, 1'b0);
   endtask

   // monitor: every valid beat must match the oldest expected beat; idle buses must be zero
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_out) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat a=%h b=%h", matrix_a_out, matrix_b_out);
            end else begin
               logic [2*N*W-1:0] e;
               e = q.pop_front();
               chkw("beat_a", matrix_a_out, e[2*N*W-1:N*W]);
               chkw("beat_b", matrix_b_out, e[N*W-1:0]);
            end
         end else begin
            chkw("idle_bus", matrix_a_out | matrix_b_out, '0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < N*N; i++) begin
         ma[i] = '0;
         mb[i] = '0;
      end
      #2;
      chkb("rst_valid", valid_out, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_done", done, 1'b0);
      chkb("rst_wr_err", wr_err, 1'b0);
      chkw("rst_buses", matrix_a_out | matrix_b_out, '0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            wr(1'b0, r*N + c, W'(r*5 + c + 1), 1'b0);
            wr(1'b1, r*N + c, W'(26 + r*5 + c), 1'b0);
         end
      q.push_back({80'h00150010000b00060001, 80'h001e001d001c001b001a});
      for (int k = 1; k < 4; k++) q.push_back({mod_a(k), mod_b(k)});
      q.push_back({80'h00190014000f000a0005, 80'h003200310030002f002e});
      pulse_start();
      finish_run(n);
      if (n != 5) begin
         total++;
         bad++;
         $display("FAIL beat_count got=%0d exp=5", n);
      end else total++;
      push_model();
      push_model();
      start = 1'b1;
      tick();
      chkb("held_first", valid_out, 1'b1);
      for (int c = 0; c < 4; c++) begin
         tick();
         chkb("held_stream", valid_out, 1'b1);
      end
      tick();
      chkb("held_done", done, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         tick();
         chkb("gap_busy", busy, c < 10);
         chkb("gap_valid", valid_out, 1'b0);
      end
      tick();
      chkb("restart_after_gap", valid_out, 1'b1);
      start = 1'b0;
      finish_run(n);
      push_model();
      pulse_start();
      tick();
      wr(1'b0, 0, 16'hFFFF, 1'b1);
      finish_run(n);
      push_model();
      pulse_start();
      finish_run(n);
      wr(1'b1, 25, 16'h0BAD, 1'b1);
      wr(1'b1, 24, 16'h00AA, 1'b0);
      for (int k = 0; k < 4; k++) q.push_back({mod_a(k), mod_b(k)});
      q.push_back({80'h00190014000f000a0005, 80'h00AA00310030002f002e});
      pulse_start();
      finish_run(n);
      push_model();
      wr_en = 1'b1;
      wr_sel = 1'b0;
      wr_addr = 5'd0;
      wr_data = 16'h1234;
      start = 1'b1;
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      chkb("same_edge_wr_err", wr_err, 1'b1);
      finish_run(n);
      push_model();
      pulse_start();
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chkb("mid_rst_valid", valid_out, 1'b0);
      chkw("mid_rst_buses", matrix_a_out | matrix_b_out, '0);
      chkb("mid_rst_done", done, 1'b0);
      chkb("mid_rst_busy", busy, 1'b0);
      q.delete();
      for (int i = 0; i < N*N; i++) begin
         ma[i] = '0;
         mb[i] = '0;
      end
      tick();
      rst_n = 1'b1;
      tick();
      chkb("post_rst_done", done, 1'b0);
      chkb("post_rst_valid", valid_out, 1'b0);
      push_model();
      pulse_start();
      finish_run(n);
      tick();
      chkw("scoreboard_drained", 80'(q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
